// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg
//   Shared definitions for the result-memory read-back streamer:
//   - FSM state encoding used by mem_stream_reader.
//   - Depth of the output buffer that absorbs the memory read latency.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Two entries are enough to hide the 1-cycle synchronous read latency
  // while still sustaining one word per cycle under continuous ready.
  localparam int BUF_DEPTH = 2;

endpackage : mem_stream_pkg

// File: rtl/mem_stream_reader_out_buf2.sv
// out_buf2
//   Two-entry synchronous FIFO holding words read back from the result
//   memory until the downstream consumer accepts them.
//
// Ports:
//   clock    in   clock, rising edge
//   Reset    in   asynchronous active-high reset (empties the FIFO)
//   clear_i  in   synchronous clear (empties the FIFO)
//   push_i   in   write data_i at the tail
//   pop_i    in   drop the head entry
//   data_i   in   Ndb-bit word to push
//   head_o   out  head entry, 0 when empty
//   occ_o    out  number of stored entries (0..2)
//   empty_o  out  no entries stored
//   full_o   out  both entries stored
module out_buf2
  import mem_stream_pkg::*;
#(
  parameter int Ndb = 8
) (
  input  logic           clock,
  input  logic           Reset,
  input  logic           clear_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [Ndb-1:0] data_i,
  output logic [Ndb-1:0] head_o,
  output logic [1:0]     occ_o,
  output logic           empty_o,
  output logic           full_o
);

  logic [Ndb-1:0] slot_q [BUF_DEPTH];
  logic           rd_ptr_q;
  logic           wr_ptr_q;
  logic [1:0]     occ_q;
  logic [1:0]     occ_d;
  logic           do_push;
  logic           do_pop;

  assign empty_o = (occ_q == 2'd0);
  assign full_o  = (occ_q == 2'(BUF_DEPTH));
  assign occ_o   = occ_q;

  // A pop only happens with data present; a push into a full buffer is
  // accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Forcing 0 on an empty buffer keeps stale words off the output bus.
  assign head_o = empty_o ? '0 : slot_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (clear_i) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

endmodule : out_buf2

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
//   Read-side counterpart of the memProcessing datapath: on each Start it
//   reads result-memory addresses 0..Nwords-1 in order and streams the words
//   out over a valid/ready interface. The memory has a 1-cycle synchronous
//   read; a 2-entry output buffer plus a credit check keep one word per
//   cycle flowing under continuous ready without overflowing on stalls.
//
// Ports:
//   clock     in   clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Init      in   synchronous clear to IDLE, overrides everything else
//   Start     in   begin a sequence (sampled in IDLE or DONE only)
//   AddrR     out  read address to the memory (its we is tied 0 outside)
//   DataR     in   memory read data, valid the cycle after AddrR
//   OutData   out  head word of the output buffer (0 when empty)
//   OutValid  out  output buffer non-empty
//   OutReady  in   consumer accepts; transfer = OutValid & OutReady
//   Busy      out  sequence in progress
//   Done      out  sequence finished (level, until Start/Init/Reset)
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int Ndb    = 8,
  parameter int Ndw    = 2,
  parameter int Nwords = 4
) (
  input  logic           clock,
  input  logic           Reset,
  input  logic           Init,
  input  logic           Start,
  output logic [Ndw-1:0] AddrR,
  input  logic [Ndb-1:0] DataR,
  output logic [Ndb-1:0] OutData,
  output logic           OutValid,
  input  logic           OutReady,
  output logic           Busy,
  output logic           Done
);

  localparam int CW = $clog2(Nwords + 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] issue_cnt_q;
  logic [CW-1:0] issue_cnt_d;
  logic [CW-1:0] sent_cnt_q;
  logic [CW-1:0] sent_cnt_d;
  logic          pending_q;
  logic          pending_d;

  logic [1:0]    buf_occ;
  logic          buf_empty;
  logic          buf_full;
  logic [Ndb-1:0] buf_head;

  logic          pop;
  logic [2:0]    credit_used;
  logic          issue;
  logic [CW-1:0] sent_next;

  // --------------------------------------------------------------------
  // Output buffer
  // --------------------------------------------------------------------
  out_buf2 #(
    .Ndb (Ndb)
  ) u_buf (
    .clock   (clock),
    .Reset   (Reset),
    .clear_i (Init),
    .push_i  (pending_q),
    .pop_i   (pop),
    .data_i  (DataR),
    .head_o  (buf_head),
    .occ_o   (buf_occ),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  assign OutValid = !buf_empty;
  assign OutData  = buf_head;
  assign pop      = OutValid && OutReady;

  // --------------------------------------------------------------------
  // Credit logic
  // A word read this cycle lands in the buffer one cycle later, so the
  // slots already committed are the stored words plus the word in flight,
  // minus the one leaving now. Issue only while that stays below depth.
  // The full term is already implied by the credit check; it is kept so
  // the one case that would overflow is visibly excluded.
  // --------------------------------------------------------------------
  assign credit_used = 3'(buf_occ) + 3'(pending_q) - 3'(pop);
  assign issue       = (state_q == RUN)
                    && (issue_cnt_q < CW'(Nwords))
                    && (credit_used < 3'(BUF_DEPTH))
                    && !(buf_full && !pop);

  assign sent_next = sent_cnt_q + CW'(pop);

  // AddrR tracks the issue counter, so it naturally holds while stalled.
  assign AddrR = Ndw'(issue_cnt_q);

  // --------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    pending_d   = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = RUN;
          issue_cnt_d = '0;
          sent_cnt_d  = '0;
        end
      end

      RUN: begin
        Busy      = 1'b1;
        pending_d = issue;
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        sent_cnt_d = sent_next;
        // The last transfer completes this cycle: finish at this edge.
        if (sent_next == CW'(Nwords)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        Done = 1'b1;
        if (Start) begin
          state_d     = RUN;
          issue_cnt_d = '0;
          sent_cnt_d  = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        issue_cnt_d = '0;
        sent_cnt_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      sent_cnt_q  <= '0;
      pending_q   <= 1'b0;
    end else if (Init) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      sent_cnt_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      pending_q   <= pending_d;
    end
  end

endmodule : mem_stream_reader

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader
//   Scoreboard bench: each accepted Start pushes the memory contents in
//   address order into a queue; a negedge monitor pops and compares on every
//   transfer and checks the output-bus rules. Directed scenarios check cycle
//   timing, stalls, Init, Start handling and asynchronous Reset; randomized
//   sequences use random memory contents and random backpressure.
module tb_mem_stream_reader;

  localparam int Ndb    = 8;
  localparam int Ndw    = 2;
  localparam int Nwords = 4;

  logic           clock    = 1'b0;
  logic           Reset    = 1'b1;
  logic           Init     = 1'b0;
  logic           Start    = 1'b0;
  logic           OutReady = 1'b0;
  logic [Ndw-1:0] AddrR;
  logic [Ndb-1:0] DataR;
  logic [Ndb-1:0] OutData;
  logic           OutValid;
  logic           Busy;
  logic           Done;

  logic [Ndb-1:0] mem [Nwords];
  logic [Ndb-1:0] exp_q [$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;

  logic           prev_stall = 1'b0;
  logic [Ndb-1:0] prev_data  = '0;

  mem_stream_reader #(
    .Ndb    (Ndb),
    .Ndw    (Ndw),
    .Nwords (Nwords)
  ) dut (
    .clock    (clock),
    .Reset    (Reset),
    .Init     (Init),
    .Start    (Start),
    .AddrR    (AddrR),
    .DataR    (DataR),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clock = ~clock;

  // Result memory: synchronous read, one cycle of latency.
  always @(posedge clock) DataR <= mem[AddrR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (Reset) begin
      prev_stall = 1'b0;
    end else begin
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h, required no transfer (t=%0t)", OutData, $time);
        end else begin
          check("word", 32'(OutData), 32'(exp_q.pop_front()));
        end
        n_xfer++;
      end
      if (!OutValid) check("empty_data_zero", 32'(OutData), 32'h0);
      if (prev_stall && OutValid) check("stall_hold", 32'(OutData), 32'(prev_data));
      check("buf_overflow", 32'(dut.u_buf.push_i && dut.u_buf.full_o), 32'h0);
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start pulse sampled at the next edge; the expected words are queued.
  // Returns in cycle 1 of the new sequence.
  task automatic start_seq();
    Start = 1'b1;
    for (int i = 0; i < Nwords; i++) exp_q.push_back(mem[i]);
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!Done && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done"}, 32'(Done), 32'h1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 32'(Busy), 32'h0);
    check({name, "_done"}, 32'(Done), 32'h0);
    check({name, "_valid"}, 32'(OutValid), 32'h0);
    check({name, "_data"}, 32'(OutData), 32'h0);
    check({name, "_addr"}, 32'(AddrR), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int k;
    mem[0] = 8'h05; mem[1] = 8'h0A; mem[2] = 8'hF0; mem[3] = 8'h33;

    // Reset state while Reset is held, then idle after release.
    #12;
    check_idle("reset");
    Reset = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      check_idle("idle_after_reset");
      tick();
    end

    // 1: continuous ready, cycle-exact timing.
    OutReady = 1'b1;
    start_seq();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t1_busy_c%0d", c), 32'(Busy), 32'((c >= 1 && c <= 6) ? 1 : 0));
      check($sformatf("t1_done_c%0d", c), 32'(Done), 32'((c >= 7) ? 1 : 0));
      check($sformatf("t1_valid_c%0d", c), 32'(OutValid), 32'((c >= 3 && c <= 6) ? 1 : 0));
      if (c <= 2) check($sformatf("t1_addr_c%0d", c), 32'(AddrR), 32'(c - 1));
      tick();
    end
    check("t1_drained", 32'(exp_q.size()), 32'h0);

    // 2: stall in cycles 3-6, then drain back-to-back.
    OutReady = 1'b0;
    start_seq();
    for (int c = 1; c <= 11; c++) begin
      OutReady = (c >= 7);
      if (c >= 3 && c <= 6) begin
        check($sformatf("t2_stall_valid_c%0d", c), 32'(OutValid), 32'h1);
        check($sformatf("t2_stall_data_c%0d", c), 32'(OutData), 32'h05);
        check($sformatf("t2_stall_addr_c%0d", c), 32'(AddrR), 32'h2);
      end
      if (c >= 7 && c <= 10) check($sformatf("t2_b2b_valid_c%0d", c), 32'(OutValid), 32'h1);
      if (c == 11) check("t2_done_c11", 32'(Done), 32'h1);
      tick();
    end
    check("t2_drained", 32'(exp_q.size()), 32'h0);

    // 3: ready toggling 1,0,1,0...
    base = n_xfer;
    OutReady = 1'b1;
    start_seq();
    k = 1;
    while (!Done && k < 40) begin
      OutReady = (k % 2 == 1);
      tick();
      k++;
    end
    check("t3_done", 32'(Done), 32'h1);
    check("t3_xfers", 32'(n_xfer - base), 32'(Nwords));
    check("t3_drained", 32'(exp_q.size()), 32'h0);

    // 4: Init after two transfers, then a full replay.
    OutReady = 1'b1;
    base = n_xfer;
    start_seq();
    k = 0;
    while (n_xfer < base + 2 && k < 20) begin
      tick();
      k++;
    end
    check("t4_two_xfers", 32'(n_xfer - base), 32'h2);
    OutReady = 1'b0;
    Init = 1'b1;
    tick();
    Init = 1'b0;
    exp_q.delete();
    check_idle("t4_after_init");
    tick();
    check_idle("t4_idle_hold");
    OutReady = 1'b1;
    start_seq();
    wait_done(20, "t4_replay");

    // 5: Start during RUN ignored; Start in DONE restarts.
    base = n_xfer;
    start_seq();
    tick();
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(20, "t5_first");
    check("t5_xfers", 32'(n_xfer - base), 32'(Nwords));
    start_seq();
    check("t5_restart_done", 32'(Done), 32'h0);
    check("t5_restart_busy", 32'(Busy), 32'h1);
    wait_done(20, "t5_second");

    // 6: asynchronous Reset mid-cycle during RUN.
    start_seq();
    tick();
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check_idle("t6_async_reset");
    exp_q.delete();
    #10;
    Reset = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      check_idle("t6_idle_after");
      tick();
    end
    start_seq();
    wait_done(20, "t6_restart");

    // Randomized sequences: random data, random backpressure, stray Starts.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < Nwords; i++) mem[i] = 8'($urandom);
      OutReady = 1'($urandom_range(0, 1));
      base = n_xfer;
      start_seq();
      k = 0;
      while (!Done && k < 200) begin
        OutReady = ($urandom_range(0, 3) != 0);
        Start    = Busy && ($urandom_range(0, 7) == 0);
        tick();
        Start = 1'b0;
        k++;
      end
      check($sformatf("rand%0d_done", s), 32'(Done), 32'h1);
      check($sformatf("rand%0d_xfers", s), 32'(n_xfer - base), 32'(Nwords));
      check($sformatf("rand%0d_drained", s), 32'(exp_q.size()), 32'h0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_stream_reader

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Reads back the result memory (one mem instance with synchronous read, 1-cycle latency) and streams its words out over a valid/ready interface.
- The memProcessing datapath writes the memory; this block is its read-side counterpart.
- Reads addresses 0..Nwords-1 once per Start command.
- Sustains 1 word/cycle under continuous ready, using a 2-entry output buffer to absorb the memory read latency under backpressure.

Parameters:
- Ndb, 8, data width of the memory word and of OutData.
- Ndw, 2, memory address width.
- Nwords, 4, words read per command; 1 <= Nwords <= 2**Ndw.

Ports:
- clock  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Init  in  1  synchronous clear to IDLE; priority over all other inputs.
- Start  in  1  begin a read sequence; sampled only in IDLE or DONE.
- AddrR  out  Ndw  read address to the mem instance; its we is tied 0 at top level.
- DataR  in  Ndb  mem data_out; valid in the cycle after AddrR was presented.
- OutData  out  Ndb  head word of the output buffer.
- OutValid  out  1  output buffer non-empty.
- OutReady  in  1  consumer accepts; transfer = OutValid & OutReady.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE (level).

Behaviour:
- Reset behaviour (Reset=1 or Init=1 at an edge):
  - state=IDLE, issue count=0, sent count=0, pending=0, buffer empty.
  - AddrR=0, OutValid=0, OutData=0, Busy=0, Done=0.
  - Reset acts at any time, including mid-sequence; partial data is discarded.
  - Init does the same synchronously.
- States:
  - IDLE: Start -> RUN, counters cleared.
  - RUN: -> DONE when sent count reaches Nwords, evaluated with this cycle's transfer.
  - DONE: Start -> RUN (new sequence, counters cleared); otherwise hold.
  - Start in RUN is ignored.
- Issue rule (RUN only):
  - AddrR = issue count (low Ndw bits).
  - A read is issued in a cycle when issue count < Nwords and occ + pending - pop < 2.
  - occ = buffer entries; pending = read issued last cycle; pop = transfer this cycle.
  - On issue: issue count += 1 at the edge, pending <= 1; otherwise pending <= 0.
  - AddrR holds its value when no read is issued.
- Return: when pending=1, DataR is written into the buffer tail at the edge ending that cycle.
  - Simultaneous push and pop are allowed; occ is unchanged.
  - Push into a full buffer cannot happen by construction; verification asserts this.
- Output:
  - OutData/OutValid come from the buffer head.
  - OutData is stable while OutValid=1 and OutReady=0.
  - OutData is 0 when the buffer is empty.
- Latency:
  - Start sampled at edge 0 -> AddrR=0 issued in cycle 1 -> word 0 enters the buffer at edge 2 -> OutValid=1 in cycle 3.
  - With OutReady=1 throughout, words appear in cycles 3..3+Nwords-1, Done=1 from cycle 3+Nwords.
- Counter widths: issue and sent counters are $clog2(Nwords+1) bits; they never wrap.
- Reads are strictly in address order, and words are output in address order.

Decomposition:
- Shared package (mem_stream_pkg):
  - State encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10; default state branch -> IDLE.
  - Buffer depth constant BUF_DEPTH=2.
- Sub-module out_buf2:
  - 2-entry synchronous FIFO, Ndb wide, with push, pop, clear (Init), asynchronous Reset.
  - Outputs head, occ[1:0], empty, full.
  - Simultaneous push and pop allowed when non-empty.
- The top level holds the FSM, issue/sent counters, pending flag and credit logic.

Test Plan:
- Memory preloaded 0x05,0x0A,0xF0,0x33; Start pulse; OutReady=1 -> OutData 0x05,0x0A,0xF0,0x33 in cycles 3-6 with OutValid=1; Done=1 from cycle 7; Busy=1 in cycles 1-6.
- Same data; OutReady=0 in cycles 3-6, then 1 -> OutData holds 0x05 during stall, at most 2 reads issued (AddrR stops at 2), then 0x05,0x0A,0xF0,0x33 back-to-back with no gaps or duplicates.
- OutReady toggling 1,0,1,0,… -> exactly 4 transfers in address order; buffer never overflows (assertion); final Done=1.
- Init=1 after 2 transfers -> next cycle state IDLE, OutValid=0, AddrR=0, Done=0; a later Start replays all 4 words from 0x05.
- Start pulsed again while RUN -> ignored, exactly 4 words output; Start in DONE -> second full sequence, Done drops in the cycle after Start.
- Reset asserted asynchronously mid-cycle during RUN -> outputs 0 immediately without waiting for a clock edge; after release, idle until Start.
